// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-lane common-data-bus arbiter with per-lane holding slots
// Round-robin between lanes; a losing lane parks its result and raises CDB_hazard until broadcast.
module cdb_arbiter #(
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [1:0]                lane_valid,
    input  logic [1:0][31:0]          lane_result,
    input  logic [1:0][PRF_IDX_W-1:0] lane_dest_prf,
    input  logic [1:0][ROB_IDX_W-1:0] lane_rob_idx,
    input  logic [1:0]                lane_take_branch,
    output logic [1:0]                CDB_hazard,
    output logic                      cdb_valid,
    output logic [31:0]               cdb_result,
    output logic [PRF_IDX_W-1:0]      cdb_dest_prf,
    output logic [ROB_IDX_W-1:0]      cdb_rob_idx,
    output logic                      cdb_take_branch,
    output logic                      cdb_lane
);

    typedef struct packed {
        logic [31:0]          result;
        logic [PRF_IDX_W-1:0] dest;
        logic [ROB_IDX_W-1:0] rob;
        logic                 take;
    } payload_t;

    payload_t [1:0] slot_q, slot_d;
    logic     [1:0] full_q, full_d;
    logic           rr_q, rr_d;
    payload_t       cdb_q, cdb_d;
    logic           cdb_valid_q, cdb_valid_d;
    logic           cdb_lane_q, cdb_lane_d;

    payload_t [1:0] lane_in;
    payload_t [1:0] offer;
    logic     [1:0] cand;
    logic           grant_v;
    logic           grant_lane;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_in[i] = {lane_result[i], lane_dest_prf[i], lane_rob_idx[i], lane_take_branch[i]};
            // A full slot masks the live input, so a hazard violation is silently dropped.
            offer[i]   = full_q[i] ? slot_q[i] : lane_in[i];
            cand[i]    = full_q[i] | lane_valid[i];
        end

        grant_v    = 1'b0;
        grant_lane = rr_q;
        if (cand[rr_q]) begin
            grant_v    = 1'b1;
            grant_lane = rr_q;
        end else if (cand[~rr_q]) begin
            grant_v    = 1'b1;
            grant_lane = ~rr_q;
        end

        slot_d      = slot_q;
        full_d      = full_q;
        rr_d        = rr_q;
        cdb_d       = cdb_q;
        cdb_valid_d = 1'b0;
        cdb_lane_d  = cdb_lane_q;

        if (squash) begin
            full_d = 2'b00;
        end else begin
            if (grant_v) begin
                cdb_d       = offer[grant_lane];
                cdb_valid_d = 1'b1;
                cdb_lane_d  = grant_lane;
                rr_d        = ~grant_lane;
            end
            for (int i = 0; i < 2; i++) begin
                if (grant_v && (grant_lane == 1'(i))) begin
                    full_d[i] = 1'b0;
                end else if (!full_q[i] && lane_valid[i]) begin
                    slot_d[i] = lane_in[i];
                    full_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q      <= '0;
            full_q      <= 2'b00;
            rr_q        <= 1'b0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_lane_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            full_q      <= full_d;
            rr_q        <= rr_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_lane_q  <= cdb_lane_d;
        end
    end

    // The registered full bits are the hazard: they already hold last cycle's next-state value.
    assign CDB_hazard      = full_q;
    assign cdb_valid       = cdb_valid_q;
    assign cdb_result      = cdb_q.result;
    assign cdb_dest_prf    = cdb_q.dest;
    assign cdb_rob_idx     = cdb_q.rob;
    assign cdb_take_branch = cdb_q.take;
    assign cdb_lane        = cdb_lane_q;

endmodule
